// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch-in-M flush,
// data-memory freeze with timeout halt, and saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int PC_W     = 7,
    parameter int MAX_WAIT = 16,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic              m_branch,
    input  logic              m_zero,
    input  logic [PC_W-1:0]   m_pc_branch,
    input  logic              m_mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              pc_src,
    output logic [PC_W-1:0]   pc_target,
    output logic              if_id_en,
    output logic              if_id_bubble,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_m_en,
    output logic              ex_m_bubble,
    output logic              m_wb_bubble,
    output logic              halted,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    localparam int WC_W = $clog2(MAX_WAIT);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            halted_nxt, flush_inc;
    logic            memstall, taken, loaduse;
    logic            freeze, resolve;

    assign memstall  = m_mem_req & ~mem_ready;
    assign taken     = m_branch & m_zero;
    assign loaduse   = ex_mem_read && (ex_dst != '0) &&
                       ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    assign pc_target = m_pc_branch;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        halted_nxt   = halted;
        freeze       = 1'b0;
        resolve      = 1'b0;
        flush_inc    = 1'b0;
        pc_en        = 1'b1;
        pc_src       = 1'b0;
        if_id_en     = 1'b1;
        if_id_bubble = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        ex_m_en      = 1'b1;
        ex_m_bubble  = 1'b0;
        m_wb_bubble  = 1'b0;

        unique case (state)
            RUN: begin
                if (memstall) begin
                    freeze       = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    // release cycle behaves like RUN with the memory access done
                    resolve      = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            HALT:    freeze = 1'b1;
            default: state_nxt = RUN;
        endcase

        if (resolve) begin
            if (taken) begin
                // ID instruction is squashed, so any load-use hit is moot
                pc_src       = 1'b1;
                if_id_bubble = 1'b1;
                id_ex_bubble = 1'b1;
                ex_m_bubble  = 1'b1;
                flush_inc    = 1'b1;
            end else if (loaduse) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        if (freeze) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_m_en     = 1'b0;
            m_wb_bubble = 1'b1;
        end

        if (reset) begin
            pc_en        = 1'b0;
            pc_src       = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_m_en      = 1'b0;
            if_id_bubble = 1'b1;
            id_ex_bubble = 1'b1;
            ex_m_bubble  = 1'b1;
            m_wb_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            halted   <= halted_nxt;
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
